// File: rtl/clock_pkg.sv
// Shared definitions for the DigitalClock button path: press-classifier state
// encoding and the default hold/repeat intervals for the 100 MHz board clock.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } press_state_e;

  localparam int unsigned HOLD_CYCLES_DFLT   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DFLT = 10_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Debounced button level in, classified press events out.
interface button_press_classifier_if;
  logic DebouncedButton;
  logic Press;
  logic Release;
  logic LongPress;
  logic Repeat;
  logic Held;

  modport master (output DebouncedButton, input Press, Release, LongPress, Repeat, Held);
  modport slave  (input DebouncedButton, output Press, Release, LongPress, Repeat, Held);
endinterface

// File: rtl/press_interval_counter.sv
// Interval counter with clear/enable; tc flags the last cycle of the selected
// (hold or repeat) interval and the count self-clears on it.
module press_interval_counter #(
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel_repeat,
  output logic tc
);

  logic [CNT_W-1:0] count_q, count_d, limit;

  always_comb begin
    limit   = sel_repeat ? CNT_W'(REPEAT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);
    tc      = en && (count_q == limit);
    count_d = count_q;
    if (clr || tc)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/button_press_classifier.sv
// Turns the debounced button level into Press/Release/LongPress/Repeat pulses.
// Define BUTTON_AUTO_REPEAT_EN to enable periodic Repeat pulses while held long.
module button_press_classifier
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DFLT,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DFLT
) (
  input  logic                      CLK,
  input  logic                      Reset,
  button_press_classifier_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  press_state_e state_q, state_d;
  logic press_q, press_d, release_q, release_d, long_q, long_d;
  logic repeat_q, repeat_d, held_q, held_d;
  logic cnt_clr, cnt_en, cnt_sel_rep, cnt_tc;
  logic btn;

  assign btn = bus.DebouncedButton;

  press_interval_counter #(
    .CNT_W        (CNT_W),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_cnt (
    .clk       (CLK),
    .rst       (Reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .sel_repeat(cnt_sel_rep),
    .tc        (cnt_tc)
  );

  // Release is tested first so it wins over a terminal count on the same edge.
  always_comb begin
    state_d     = state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cnt_sel_rep = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = SHORT;
          press_d = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      SHORT: begin
        cnt_en = 1'b1;
        if (!btn) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_clr   = 1'b1;
        end else if (cnt_tc) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        cnt_en      = 1'b1;
        cnt_sel_rep = 1'b1;
`endif
        if (!btn) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_clr   = 1'b1;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (cnt_tc) begin
          repeat_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus.Press     = press_q;
  assign bus.Release   = release_q;
  assign bus.LongPress = long_q;
  assign bus.Repeat    = repeat_q;
  assign bus.Held      = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Randomized and directed bench for button_press_classifier against an
// event-time model (cycles since press) of the press classification rules.
module tb_button_press_classifier;

  localparam int HOLD = 8;
  localparam int REP  = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  button_press_classifier_if bif();

  button_press_classifier #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bif.slave)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model: whether the button is considered down and edges elapsed since press.
  bit m_pressed = 1'b0;
  int m_n       = 0;
  bit e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_rep = 1'b0, e_held = 1'b0;

  int q_press[$], q_rel[$], q_long[$], q_rep[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_pressed <= 1'b0;
      m_n       <= 0;
      e_press   <= 1'b0;
      e_rel     <= 1'b0;
      e_long    <= 1'b0;
      e_rep     <= 1'b0;
      e_held    <= 1'b0;
    end else begin
      automatic bit p = 1'b0, r = 1'b0, l = 1'b0, rp = 1'b0;
      automatic bit down = m_pressed;
      automatic int n = m_n;
      if (!down && bif.DebouncedButton) begin
        p = 1'b1; down = 1'b1; n = 0;
      end else if (down && !bif.DebouncedButton) begin
        r = 1'b1; down = 1'b0;
      end else if (down) begin
        n = n + 1;
        if (n == HOLD) l = 1'b1;
        else if (REP_EN && n > HOLD && ((n - HOLD) % REP) == 0) rp = 1'b1;
      end
      m_pressed <= down;
      m_n       <= n;
      e_press   <= p;
      e_rel     <= r;
      e_long    <= l;
      e_rep     <= rp;
      e_held    <= down;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    chk("outputs{press,rel,long,rep,held}",
        int'({bif.Press, bif.Release, bif.LongPress, bif.Repeat, bif.Held}),
        int'({e_press, e_rel, e_long, e_rep, e_held}));
    if (bif.Press)     q_press.push_back(cyc);
    if (bif.Release)   q_rel.push_back(cyc);
    if (bif.LongPress) q_long.push_back(cyc);
    if (bif.Repeat)    q_rep.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clr_q();
    q_press.delete(); q_rel.delete(); q_long.delete(); q_rep.delete();
  endtask

  function automatic int dt(input int a_ok, input int a, input int b_ok, input int b);
    return (a_ok != 0 && b_ok != 0) ? a - b : -999;
  endfunction

  initial begin
    bif.DebouncedButton = 1'b0;
    step(3);
    Reset = 1'b0;

    // Idle line: no events at all.
    clr_q();
    step(20);
    chk("s1_idle_events", q_press.size() + q_rel.size() + q_long.size() + q_rep.size(), 0);

    // Short tap of three sampled highs.
    clr_q();
    bif.DebouncedButton = 1'b1; step(3);
    bif.DebouncedButton = 1'b0; step(4);
    chk("s2_press_cnt", q_press.size(), 1);
    chk("s2_rel_minus_press", dt(q_rel.size(), q_rel.size() ? q_rel[0] : 0,
                                 q_press.size(), q_press.size() ? q_press[0] : 0), 3);
    chk("s2_long_cnt", q_long.size(), 0);

    // Long hold of 30 sampled highs.
    clr_q();
    bif.DebouncedButton = 1'b1; step(30);
    bif.DebouncedButton = 1'b0; step(3);
    chk("s3_press_cnt", q_press.size(), 1);
    chk("s3_long_minus_press", dt(q_long.size(), q_long.size() ? q_long[0] : 0,
                                  q_press.size(), q_press.size() ? q_press[0] : 0), 8);
    chk("s3_rep_cnt", q_rep.size(), REP_EN ? 5 : 0);
    if (REP_EN) begin
      chk("s3_rep0_minus_press", dt(q_rep.size(), q_rep.size() ? q_rep[0] : 0,
                                    q_press.size(), q_press.size() ? q_press[0] : 0), 12);
      chk("s3_rep4_minus_press", dt(q_rep.size() >= 5, q_rep.size() >= 5 ? q_rep[4] : 0,
                                    q_press.size(), q_press.size() ? q_press[0] : 0), 28);
    end
    chk("s3_rel_minus_press", dt(q_rel.size(), q_rel.size() ? q_rel[0] : 0,
                                 q_press.size(), q_press.size() ? q_press[0] : 0), 30);

    // Drop exactly on the hold terminal-count edge: Release wins.
    clr_q();
    bif.DebouncedButton = 1'b1; step(8);
    bif.DebouncedButton = 1'b0; step(3);
    chk("s4_long_cnt", q_long.size(), 0);
    chk("s4_rel_minus_press", dt(q_rel.size(), q_rel.size() ? q_rel[0] : 0,
                                 q_press.size(), q_press.size() ? q_press[0] : 0), 8);

    // Async reset while in LONG, button still held across reset release.
    bif.DebouncedButton = 1'b1; step(11);
    chk("s5_held_before_rst", int'(bif.Held), 1);
    Reset = 1'b1; #1;
    chk("s5_async_rst_outputs",
        int'({bif.Press, bif.Release, bif.LongPress, bif.Repeat, bif.Held}), 0);
    clr_q();
    step(2);
    Reset = 1'b0;
    step(2);
    chk("s5_rel_cnt", q_rel.size(), 0);
    chk("s5_press_cnt", q_press.size(), 1);
    bif.DebouncedButton = 1'b0; step(3);

    // Back-to-back re-press straight out of the Release cycle.
    clr_q();
    bif.DebouncedButton = 1'b1; step(1);
    bif.DebouncedButton = 1'b0; step(1);
    bif.DebouncedButton = 1'b1; step(1);
    bif.DebouncedButton = 1'b0; step(3);
    chk("s7_press_cnt", q_press.size(), 2);
    chk("s7_rel_cnt", q_rel.size(), 2);

    // Random runs, occasional long holds and mid-cycle resets.
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bif.DebouncedButton = 1'b1; step($urandom_range(20, 40));
      end else if ($urandom_range(0, 19) == 0) begin
        Reset = 1'b1; #($urandom_range(1, 3));
        step($urandom_range(1, 3));
        bif.DebouncedButton = 1'($urandom_range(0, 1));
        Reset = 1'b0;
        step(1);
      end else begin
        bif.DebouncedButton = 1'($urandom_range(0, 1));
        step($urandom_range(1, 12));
      end
    end
    bif.DebouncedButton = 1'b0; step(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
